// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : systolic_pkg                                                    |
// | Purpose  : Shared definitions for the systolic interpolator sequencer:     |
// |            FSM state encoding and default configuration constants.         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package systolic_pkg;

  // Default configuration
  localparam int C_WORDLENGTH = 16;
  localparam int C_NTAPS      = 8;
  localparam int C_MIN_GAP    = 18;

  // Gap timer width; covers the full legal MIN_GAP range of 4..255
  localparam int C_GAP_W      = 8;

  // Sequencer FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_gap_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : systolic_gap_timer                                              |
// | Purpose  : Loadable down-counter that spaces successive advance pulses.    |
// |            Counts down by one per clock and holds at zero.                 |
// | Ports    : clk30x  - system clock                                          |
// |            reset_n - asynchronous active-low reset                         |
// |            load    - load 'value' on the next edge                         |
// |            value   - reload value                                          |
// |            zero    - count has reached zero                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module systolic_gap_timer
  import systolic_pkg::*;
#(
  parameter int WIDTH = C_GAP_W
) (
  input  logic             clk30x,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk30x or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/systolic_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : systolic_sequencer                                              |
// | Purpose  : Sequencing controller for the 8-PE systolic interpolator        |
// |            wrapper. Buffers one incoming sample, issues rate-limited       |
// |            'donext' advance pulses and captures the interpolated result.   |
// | Ports    : clk30x, reset_n      - clock, async active-low reset            |
// |            run                  - enables issuing of new advances          |
// |            sample_valid/in      - sample strobe and value                  |
// |            filt_word            - wrapper output word                      |
// |            donext, pe_word      - advance pulse and word to the wrapper    |
// |            out_word, out_valid  - captured result and qualifier            |
// |            overflow             - sticky sample-dropped flag               |
// |            busy                 - advance in progress or sample pending    |
// |            drop_cnt             - saturating drop count (optional)         |
// | Config   : define SYSTOLIC_SEQ_DROPCNT_EN to add the drop_cnt output.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int WORDLENGTH = C_WORDLENGTH,
  parameter int MIN_GAP    = C_MIN_GAP,
  parameter int NTAPS      = C_NTAPS
) (
  input  logic                  clk30x,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  sample_valid,
  input  logic [WORDLENGTH-1:0] sample_in,
  input  logic [WORDLENGTH-1:0] filt_word,
  output logic                  donext,
  output logic [WORDLENGTH-1:0] pe_word,
  output logic [WORDLENGTH-1:0] out_word,
  output logic                  out_valid,
  output logic                  overflow,
  output logic                  busy
`ifdef SYSTOLIC_SEQ_DROPCNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int                 PRIME_W      = $clog2(NTAPS + 1);
  localparam logic [C_GAP_W-1:0] C_GAP_LOAD   = C_GAP_W'(MIN_GAP - 1);
  localparam logic [PRIME_W-1:0] C_PRIME_FULL = PRIME_W'(NTAPS);

  seq_state_t            r_state;
  seq_state_t            w_next_state;

  logic                  r_pend_full;
  logic [WORDLENGTH-1:0] r_pend_word;
  logic [WORDLENGTH-1:0] r_pe_word;
  logic [WORDLENGTH-1:0] r_out_word;
  logic                  r_out_valid;
  logic                  r_overflow;
  logic [PRIME_W-1:0]    r_prime_cnt;

  logic                  w_in_issue;
  logic                  w_issue_req;
  logic                  w_enter_issue;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_gap_zero;

  // A strobe arriving this cycle counts as pending for the issue decision,
  // so a sample strobed while idle is advanced on the very next cycle.
  assign w_in_issue    = (r_state == ST_ISSUE);
  assign w_issue_req   = run && (r_pend_full || sample_valid);
  assign w_enter_issue = (w_next_state == ST_ISSUE);

  // The buffer is emptied during ISSUE, so a strobe in that cycle is kept.
  assign w_accept      = sample_valid && (!r_pend_full || w_in_issue);
  assign w_drop        = sample_valid && !w_accept;

  // Timer is loaded on entry to ISSUE so the count reads MIN_GAP-1 during
  // ISSUE and reaches zero MIN_GAP-1 cycles later, in the last GAP cycle.
  systolic_gap_timer #(
    .WIDTH (C_GAP_W)
  ) u_gap_timer (
    .clk30x  (clk30x),
    .reset_n (reset_n),
    .load    (w_enter_issue),
    .value   (C_GAP_LOAD),
    .zero    (w_gap_zero)
  );

  // FSM: state register
  always_ff @(posedge clk30x or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_issue_req) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = ST_SETTLE;
      ST_SETTLE:  w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_GAP;
      // Falling straight through IDLE keeps the back-to-back period at
      // exactly MIN_GAP instead of MIN_GAP+1.
      ST_GAP: begin
        if (w_gap_zero) begin
          w_next_state = w_issue_req ? ST_ISSUE : ST_IDLE;
        end
      end
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    donext = w_in_issue;
    busy   = (r_state != ST_IDLE) || r_pend_full;
  end

  // Pending buffer, advance word, priming count and result capture
  always_ff @(posedge clk30x or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_full <= 1'b0;
      r_pend_word <= '0;
      r_pe_word   <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_prime_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_pend_word <= sample_in;
        r_pend_full <= 1'b1;
      end else if (w_in_issue) begin
        r_pend_full <= 1'b0;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      // Word is presented during ISSUE so the wrapper sees it on the
      // donext edge; it is held until the next advance.
      if (w_enter_issue) begin
        r_pe_word <= r_pend_full ? r_pend_word : sample_in;
      end

      if (w_in_issue && (r_prime_cnt != C_PRIME_FULL)) begin
        r_prime_cnt <= r_prime_cnt + 1'b1;
      end

      r_out_valid <= 1'b0;
      if (r_state == ST_CAPTURE) begin
        r_out_word  <= filt_word;
        r_out_valid <= (r_prime_cnt == C_PRIME_FULL);
      end
    end
  end

  assign pe_word   = r_pe_word;
  assign out_word  = r_out_word;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;

`ifdef SYSTOLIC_SEQ_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk30x or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire
